// File: rtl/line_refill_ctrl.sv
// Miss-side refill engine for the split I/D caches: arbitrates misses (dcache first),
// fetches one line from memory and returns it to the owning cache as a single-cycle fill.
module line_refill_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int IDX_W   = 5,
  parameter int OFF_W   = 3,
  parameter int TIMEOUT = 255
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_miss,
  input  logic [ADDR_W-1:0]              i_addr,
  input  logic                           d_miss,
  input  logic [ADDR_W-1:0]              d_addr,
  output logic                           mem_req,
  output logic [ADDR_W-1:0]              mem_addr,
  input  logic [63:0]                    mem_rdata,
  input  logic                           mem_rvalid,
  output logic                           i_fill,
  output logic                           d_fill,
  output logic [63:0]                    fill_line,
  output logic [IDX_W-1:0]               fill_idx,
  output logic [ADDR_W-IDX_W-OFF_W-1:0]  fill_tag,
  output logic                           i_stall,
  output logic                           d_stall,
  output logic                           err
);

  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam int LA_W  = ADDR_W - OFF_W;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, FILL} state_e;

  state_e            state_q, state_d;
  logic              own_dc_q, own_dc_d;
  logic [LA_W-1:0]   line_addr_q, line_addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [63:0]       line_q, line_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              err_q, err_d;

  // Only the line address is kept; the byte offset never reaches memory or the tags.
  logic unused_off;
  assign unused_off = ^{i_addr[OFF_W-1:0], d_addr[OFF_W-1:0]};

  always_comb begin
    state_d     = state_q;
    own_dc_d    = own_dc_q;
    line_addr_d = line_addr_q;
    cnt_d       = cnt_q;
    line_d      = line_q;
    idx_d       = idx_q;
    tag_d       = tag_q;
    err_d       = err_q;
    unique case (state_q)
      IDLE: begin
        if (d_miss) begin
          line_addr_d = d_addr[ADDR_W-1:OFF_W];
          own_dc_d    = 1'b1;
          cnt_d       = '0;
          state_d     = REQ;
        end else if (i_miss) begin
          line_addr_d = i_addr[ADDR_W-1:OFF_W];
          own_dc_d    = 1'b0;
          cnt_d       = '0;
          state_d     = REQ;
        end
      end
      REQ: begin
        // A response in the last allowed cycle still wins over the timeout.
        if (mem_rvalid) begin
          line_d  = mem_rdata;
          idx_d   = line_addr_q[IDX_W-1:0];
          tag_d   = line_addr_q[LA_W-1:IDX_W];
          cnt_d   = '0;
          state_d = FILL;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      FILL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      own_dc_q    <= 1'b1;
      line_addr_q <= '0;
      cnt_q       <= '0;
      line_q      <= '0;
      idx_q       <= '0;
      tag_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      own_dc_q    <= own_dc_d;
      line_addr_q <= line_addr_d;
      cnt_q       <= cnt_d;
      line_q      <= line_d;
      idx_q       <= idx_d;
      tag_q       <= tag_d;
      err_q       <= err_d;
    end
  end

  assign mem_req   = (state_q == REQ);
  assign mem_addr  = mem_req ? {line_addr_q, {OFF_W{1'b0}}} : '0;
  assign i_fill    = (state_q == FILL) & ~own_dc_q;
  assign d_fill    = (state_q == FILL) & own_dc_q;
  assign fill_line = line_q;
  assign fill_idx  = idx_q;
  assign fill_tag  = tag_q;
  assign err       = err_q;
  assign i_stall   = i_miss | ((state_q != IDLE) & ~own_dc_q);
  assign d_stall   = d_miss | ((state_q != IDLE) & own_dc_q);

endmodule

// File: tb/tb_line_refill_ctrl.sv
// Bench for line_refill_ctrl: a vector table, directed multi-cycle sequences and a
// randomized run, all checked every cycle against a transaction-level reference model.
module tb_line_refill_ctrl;

  localparam int TIMEOUT = 4;

  logic        clk, rst_n, i_miss, d_miss, mem_rvalid;
  logic [31:0] i_addr, d_addr, mem_addr;
  logic [63:0] mem_rdata, fill_line;
  logic        mem_req, i_fill, d_fill, i_stall, d_stall, err;
  logic [4:0]  fill_idx;
  logic [23:0] fill_tag;

  line_refill_ctrl #(.ADDR_W(32), .IDX_W(5), .OFF_W(3), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_miss(i_miss), .i_addr(i_addr), .d_miss(d_miss), .d_addr(d_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .i_fill(i_fill), .d_fill(d_fill), .fill_line(fill_line), .fill_idx(fill_idx),
    .fill_tag(fill_tag), .i_stall(i_stall), .d_stall(d_stall), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n, i_miss;
    logic [31:0] i_addr;
    logic        d_miss;
    logic [31:0] d_addr;
    logic        rv;
    logic [63:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_ifill, e_dfill;
    logic [63:0] e_line;
    logic [4:0]  e_idx;
    logic [23:0] e_tag;
    logic        e_istall, e_dstall, e_err;
  } vec_t;

  int vectors, miscompares;
  bit check_en;

  // Reference model: busy/filling flags plus the cycles already spent waiting on memory.
  bit          m_busy, m_fill, m_own_d, m_err;
  logic [31:0] m_addr;
  logic [63:0] m_line;
  logic [4:0]  m_idx;
  logic [23:0] m_tag;
  int          m_wait;
  bit          exp_i_fill, exp_d_fill, prev_req;

  logic [31:0] req_log[$];
  logic [5:0]  fill_log[$];
  logic [31:0] i_q[$], d_q[$];

  function automatic vec_t mkVec(logic im, logic [31:0] ia, logic dm, logic [31:0] da,
                                 logic rv, logic [63:0] rd, logic er, logic [31:0] ea,
                                 logic eif, logic edf, logic [63:0] el, logic [4:0] ei,
                                 logic [23:0] et, logic eis, logic eds, logic ee);
    vec_t v;
    v.rst_n = 1'b1; v.i_miss = im; v.i_addr = ia; v.d_miss = dm; v.d_addr = da;
    v.rv = rv; v.rdata = rd; v.e_req = er; v.e_addr = ea; v.e_ifill = eif; v.e_dfill = edf;
    v.e_line = el; v.e_idx = ei; v.e_tag = et; v.e_istall = eis; v.e_dstall = eds; v.e_err = ee;
    return v;
  endfunction

  task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    logic [31:0] e_addr;
    e_addr     = (m_busy && !m_fill) ? {m_addr[31:3], 3'b000} : 32'h0;
    exp_i_fill = m_fill && !m_own_d;
    exp_d_fill = m_fill && m_own_d;
    if (mem_req === 1'b1 && !prev_req) req_log.push_back(mem_addr);
    prev_req = (mem_req === 1'b1);
    if (i_fill === 1'b1 || d_fill === 1'b1) fill_log.push_back({d_fill, fill_idx});
    if (!check_en) return;
    checkValue("mem_req",   mem_req,   m_busy && !m_fill);
    checkValue("mem_addr",  mem_addr,  e_addr);
    checkValue("i_fill",    i_fill,    exp_i_fill);
    checkValue("d_fill",    d_fill,    exp_d_fill);
    checkValue("fill_line", fill_line, m_line);
    checkValue("fill_idx",  fill_idx,  m_idx);
    checkValue("fill_tag",  fill_tag,  m_tag);
    checkValue("i_stall",   i_stall,   i_miss || (m_busy && !m_own_d));
    checkValue("d_stall",   d_stall,   d_miss || (m_busy && m_own_d));
    checkValue("err",       err,       m_err);
  endtask

  task automatic modelStep();
    if (!rst_n) begin
      m_busy = 0; m_fill = 0; m_own_d = 1; m_err = 0; m_wait = 0;
      m_addr = '0; m_line = '0; m_idx = '0; m_tag = '0;
    end else if (!m_busy) begin
      if (d_miss) begin
        m_busy = 1; m_own_d = 1; m_addr = d_addr; m_wait = 0;
      end else if (i_miss) begin
        m_busy = 1; m_own_d = 0; m_addr = i_addr; m_wait = 0;
      end
    end else if (m_fill) begin
      m_busy = 0; m_fill = 0;
    end else if (mem_rvalid) begin
      m_fill = 1; m_line = mem_rdata; m_idx = m_addr[7:3]; m_tag = m_addr[31:8];
    end else if (m_wait + 1 >= TIMEOUT) begin
      m_busy = 0; m_err = 1;
    end else begin
      m_wait++;
    end
  endtask

  task automatic applyStimulus(input logic r, input logic im, input logic [31:0] ia,
                               input logic dm, input logic [31:0] da,
                               input logic rv, input logic [63:0] rd);
    @(negedge clk);
    rst_n = r; i_miss = im; i_addr = ia; d_miss = dm; d_addr = da;
    mem_rvalid = rv; mem_rdata = rd;
    #1;
    checkOutput();
    modelStep();
  endtask

  // Emulates both caches: each holds its miss until its fill pulse, memory answers after lat cycles.
  task automatic runCaches(input int lat, input bit rv_in_fill, input int max_cycles);
    int n;
    n = 0;
    while ((i_q.size() > 0 || d_q.size() > 0) && n < max_cycles) begin
      logic im, dm, rv;
      logic [31:0] ia, da;
      im = (i_q.size() > 0);
      dm = (d_q.size() > 0);
      ia = im ? i_q[0] : 32'h0;
      da = dm ? d_q[0] : 32'h0;
      rv = (m_busy && !m_fill && m_wait == lat) || (m_fill && rv_in_fill);
      applyStimulus(1'b1, im, ia, dm, da, rv, {$urandom(), $urandom()});
      if (im) checkValue("i_stall_held", i_stall, 1);
      if (exp_i_fill) void'(i_q.pop_front());
      if (exp_d_fill) void'(d_q.pop_front());
      n++;
    end
    checkValue("serve_bound", i_q.size() + d_q.size(), 0);
  endtask

  vec_t tbl[9];

  initial begin
    vectors = 0; miscompares = 0; check_en = 0; prev_req = 0;
    rst_n = 0; i_miss = 0; d_miss = 0; i_addr = 0; d_addr = 0; mem_rvalid = 0; mem_rdata = 0;

    tbl[0] = mkVec(0, 0, 1, 32'h1234, 0, 0,                     0, 32'h0,    0, 0, 64'h0, 0, 24'h0, 0, 1, 0);
    tbl[1] = mkVec(0, 0, 1, 32'h1234, 0, 0,                     1, 32'h1230, 0, 0, 64'h0, 0, 24'h0, 0, 1, 0);
    tbl[2] = mkVec(0, 0, 1, 32'h1234, 0, 0,                     1, 32'h1230, 0, 0, 64'h0, 0, 24'h0, 0, 1, 0);
    tbl[3] = mkVec(0, 0, 1, 32'h1234, 0, 0,                     1, 32'h1230, 0, 0, 64'h0, 0, 24'h0, 0, 1, 0);
    tbl[4] = mkVec(0, 0, 1, 32'h1234, 1, 64'h0807060504030201, 1, 32'h1230, 0, 0, 64'h0, 0, 24'h0, 0, 1, 0);
    tbl[5] = mkVec(0, 0, 1, 32'h1234, 0, 0,                     0, 32'h0,    0, 1, 64'h0807060504030201, 6, 24'h12, 0, 1, 0);
    tbl[6] = mkVec(0, 0, 0, 32'h0,    0, 0,                     0, 32'h0,    0, 0, 64'h0807060504030201, 6, 24'h12, 0, 0, 0);
    tbl[7] = mkVec(0, 0, 0, 32'h0,    1, 64'hFFFF,              0, 32'h0,    0, 0, 64'h0807060504030201, 6, 24'h12, 0, 0, 0);
    tbl[8] = mkVec(0, 0, 0, 32'h0,    0, 0,                     0, 32'h0,    0, 0, 64'h0807060504030201, 6, 24'h12, 0, 0, 0);

    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    check_en = 1;

    $display("[TB] vector table: single dcache miss");
    for (int i = 0; i < 9; i++) begin
      applyStimulus(tbl[i].rst_n, tbl[i].i_miss, tbl[i].i_addr, tbl[i].d_miss, tbl[i].d_addr,
                    tbl[i].rv, tbl[i].rdata);
      checkValue($sformatf("tbl%0d_mem_req", i),   mem_req,   tbl[i].e_req);
      checkValue($sformatf("tbl%0d_mem_addr", i),  mem_addr,  tbl[i].e_addr);
      checkValue($sformatf("tbl%0d_i_fill", i),    i_fill,    tbl[i].e_ifill);
      checkValue($sformatf("tbl%0d_d_fill", i),    d_fill,    tbl[i].e_dfill);
      checkValue($sformatf("tbl%0d_fill_line", i), fill_line, tbl[i].e_line);
      checkValue($sformatf("tbl%0d_fill_idx", i),  fill_idx,  tbl[i].e_idx);
      checkValue($sformatf("tbl%0d_fill_tag", i),  fill_tag,  tbl[i].e_tag);
      checkValue($sformatf("tbl%0d_i_stall", i),   i_stall,   tbl[i].e_istall);
      checkValue($sformatf("tbl%0d_d_stall", i),   d_stall,   tbl[i].e_dstall);
      checkValue($sformatf("tbl%0d_err", i),       err,       tbl[i].e_err);
    end

    $display("[TB] simultaneous I and D miss");
    req_log.delete(); fill_log.delete();
    i_q.push_back(32'h0040_0008);
    d_q.push_back(32'h1000_0010);
    runCaches(2, 0, 60);
    checkValue("both_req_count", req_log.size(), 2);
    checkValue("both_req0", (req_log.size() > 0) ? req_log[0] : 32'hDEAD_BEEF, 32'h1000_0010);
    checkValue("both_req1", (req_log.size() > 1) ? req_log[1] : 32'hDEAD_BEEF, 32'h0040_0008);
    checkValue("both_fill_count", fill_log.size(), 2);
    checkValue("both_fill0", (fill_log.size() > 0) ? fill_log[0] : 6'h3F, 6'h22);
    checkValue("both_fill1", (fill_log.size() > 1) ? fill_log[1] : 6'h3F, 6'h01);

    $display("[TB] stray mem_rvalid in FILL and IDLE");
    fill_log.delete();
    d_q.push_back(32'h0000_2040);
    runCaches(1, 1, 30);
    applyStimulus(1, 0, 0, 0, 0, 1, 64'h1111);
    applyStimulus(1, 0, 0, 0, 0, 1, 64'h2222);
    checkValue("stray_mem_req", mem_req, 0);
    checkValue("stray_fill_count", fill_log.size(), 1);

    $display("[TB] timeout and retry");
    fill_log.delete();
    applyStimulus(1, 0, 0, 1, 32'h0000_3000, 0, 0);
    checkValue("to_err_clear", err, 0);
    for (int k = 0; k < TIMEOUT; k++) begin
      applyStimulus(1, 0, 0, 1, 32'h0000_3000, 0, 0);
      checkValue("to_req_high", mem_req, 1);
    end
    applyStimulus(1, 0, 0, 1, 32'h0000_3000, 0, 0);
    checkValue("to_req_drop", mem_req, 0);
    checkValue("to_err_set", err, 1);
    d_q.push_back(32'h0000_3000);
    runCaches(1, 0, 30);
    checkValue("to_err_sticky", err, 1);
    checkValue("to_fill_count", fill_log.size(), 1);

    $display("[TB] reset during REQ");
    fill_log.delete();
    applyStimulus(1, 0, 0, 1, 32'h0000_4418, 0, 0);
    applyStimulus(1, 0, 0, 1, 32'h0000_4418, 0, 0);
    applyStimulus(0, 0, 0, 1, 32'h0000_4418, 0, 0);
    applyStimulus(1, 0, 0, 1, 32'h0000_4418, 1, 64'hBAD0_BAD0);
    checkValue("rst_req_low", mem_req, 0);
    checkValue("rst_err_clear", err, 0);
    applyStimulus(1, 0, 0, 1, 32'h0000_4418, 0, 0);
    checkValue("rst_req_fresh", mem_req, 1);
    checkValue("rst_no_fill", fill_log.size(), 0);
    d_q.push_back(32'h0000_4418);
    runCaches(1, 0, 30);

    $display("[TB] back-to-back dcache misses, lines 31 then 0");
    fill_log.delete();
    d_q.push_back(32'h0000_00F8);
    d_q.push_back(32'h0000_0100);
    runCaches(3, 0, 60);
    checkValue("b2b_fill_count", fill_log.size(), 2);
    checkValue("b2b_fill0", (fill_log.size() > 0) ? fill_log[0] : 6'h00, 6'h3F);
    checkValue("b2b_fill1", (fill_log.size() > 1) ? fill_log[1] : 6'h00, 6'h20);

    $display("[TB] randomized run");
    for (int c = 0; c < 3000; c++) begin
      applyStimulus(($urandom_range(0, 63) != 0), 1'($urandom_range(0, 1)), $urandom(),
                    1'($urandom_range(0, 1)), $urandom(), ($urandom_range(0, 2) == 0),
                    {$urandom(), $urandom()});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
